// File: rtl/csa8_sched_pkg.sv
// csa8_sched_pkg: shared types and constants for the serial wide-add scheduler.
//   SLICE_W        width of the shared adder slice
//   sched_state_e  sequencer states
//   req_id_t       requester index
//   nslice()       adder passes needed for a given operand width
package csa8_sched_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_e;

  typedef logic req_id_t;

  function automatic int nslice(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/carry_select_adder8.sv
// carry_select_adder8: 8-bit carry-select adder slice.
// The upper nibble is computed for both carry-in values and selected by the
// lower nibble's carry.
//   a, b  input  8  operands
//   cin   input  1  carry-in
//   sum   output 8  a + b + cin (low 8 bits)
//   cout  output 1  carry out of bit 7
module carry_select_adder8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [4:0] lo;
  logic [4:0] hi0;
  logic [4:0] hi1;

  assign lo  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, cin};
  assign hi0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
  assign hi1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;

  assign sum  = {(lo[4] ? hi1[3:0] : hi0[3:0]), lo[3:0]};
  assign cout = lo[4] ? hi1[4] : hi0[4];

endmodule

// File: rtl/csa8_rr_arb2.sv
// csa8_rr_arb2: combinational 2-way round-robin arbiter.
//   valid   input  2  request valids
//   rr_ptr  input  1  preferred requester when both are valid
//   grant   output 2  one-hot grant (zero when nothing is valid)
//   gnt_id  output 1  index of the granted requester
import csa8_sched_pkg::*;

module csa8_rr_arb2 (
  input  logic [1:0] valid,
  input  req_id_t    rr_ptr,
  output logic [1:0] grant,
  output req_id_t    gnt_id
);

  always_comb begin
    grant  = 2'b00;
    gnt_id = 1'b0;
    if (valid == 2'b11) begin
      gnt_id = rr_ptr;
      grant  = rr_ptr ? 2'b10 : 2'b01;
    end else if (valid[1]) begin
      gnt_id = 1'b1;
      grant  = 2'b10;
    end else if (valid[0]) begin
      gnt_id = 1'b0;
      grant  = 2'b01;
    end
  end

endmodule

// File: rtl/csa8_wide_add_sched.sv
// csa8_wide_add_sched: WIDTH-bit adds for two requesters, done serially one
// byte per cycle on a single shared carry_select_adder8.
//   clk, rst_n                   clock, async active-low reset
//   req0_* / req1_*              valid/ready request ports with a, b, cin
//   rsp_valid / rsp_ready        response handshake
//   rsp_sum, rsp_cout, rsp_id    result, carry out, requester served
//   rsp_ovf                      signed overflow, only with CSA8_SCHED_OVF_EN
//
// state | meaning
// IDLE  | arbitrate; accept one request from the granted requester
// RUN   | one byte slice per cycle, carry held in carry_reg
// DONE  | result presented on rsp_*, held until rsp_ready
import csa8_sched_pkg::*;

module csa8_wide_add_sched #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id
`ifdef CSA8_SCHED_OVF_EN
  ,
  output logic             rsp_ovf
`endif
);

  localparam int NSLICE = nslice(WIDTH);
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  if (WIDTH < SLICE_W || (WIDTH % SLICE_W) != 0) begin : g_bad_width
    $error("csa8_wide_add_sched: WIDTH must be a non-zero multiple of 8");
  end

  sched_state_e     state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [IDX_W-1:0] slice_idx;
  logic             carry_reg;
  logic             cout_reg;
  req_id_t          id_reg;
  req_id_t          rr_ptr;

  logic [1:0]       grant;
  req_id_t          gnt_id;
  logic             accept;

  logic [SLICE_W-1:0] add_a;
  logic [SLICE_W-1:0] add_b;
  logic [SLICE_W-1:0] add_sum;
  logic               add_cout;

  csa8_rr_arb2 u_arb (
    .valid  ({req1_valid, req0_valid}),
    .rr_ptr (rr_ptr),
    .grant  (grant),
    .gnt_id (gnt_id)
  );

  // state resets to IDLE, so ready must also be gated by rst_n itself
  assign req0_ready = rst_n && (state == IDLE) && grant[0];
  assign req1_ready = rst_n && (state == IDLE) && grant[1];
  assign accept     = (state == IDLE) && (grant != 2'b00);

  always_comb begin
    add_a = a_reg[int'(slice_idx) * SLICE_W +: SLICE_W];
    add_b = b_reg[int'(slice_idx) * SLICE_W +: SLICE_W];
  end

  carry_select_adder8 u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_reg),
    .sum  (add_sum),
    .cout (add_cout)
  );

`ifdef CSA8_SCHED_OVF_EN
  logic ovf_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (state == RUN && slice_idx == LAST_IDX) begin
      ovf_reg <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                 (add_sum[SLICE_W-1] != a_reg[WIDTH-1]);
    end
  end

  assign rsp_ovf = ovf_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      slice_idx <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      id_reg    <= 1'b0;
      rr_ptr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg     <= gnt_id ? req1_a : req0_a;
            b_reg     <= gnt_id ? req1_b : req0_b;
            carry_reg <= gnt_id ? req1_cin : req0_cin;
            id_reg    <= gnt_id;
            slice_idx <= '0;
            rr_ptr    <= ~gnt_id;
            state     <= RUN;
          end
        end
        RUN: begin
          sum_reg[int'(slice_idx) * SLICE_W +: SLICE_W] <= add_sum;
          carry_reg <= add_cout;
          if (slice_idx == LAST_IDX) begin
            cout_reg <= add_cout;
            state    <= DONE;
          end else begin
            slice_idx <= slice_idx + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = (state == DONE);
  assign rsp_sum   = sum_reg;
  assign rsp_cout  = cout_reg;
  assign rsp_id    = id_reg;

endmodule

// File: tb/tb_csa8_wide_add_sched.sv
// tb_csa8_wide_add_sched: directed bench for csa8_wide_add_sched at WIDTH=32
// and WIDTH=8. Define CSA8_SCHED_OVF_EN to also cover rsp_ovf.
module tb_csa8_wide_add_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_cin;
  logic        req1_valid, req1_ready, req1_cin;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_cout, rsp_id;
  logic [31:0] rsp_sum;

  logic       d8_req0_valid, d8_req0_ready, d8_req0_cin;
  logic       d8_req1_valid, d8_req1_ready, d8_req1_cin;
  logic [7:0] d8_req0_a, d8_req0_b, d8_req1_a, d8_req1_b;
  logic       d8_rsp_valid, d8_rsp_ready, d8_rsp_cout, d8_rsp_id;
  logic [7:0] d8_rsp_sum;

`ifdef CSA8_SCHED_OVF_EN
  logic rsp_ovf, d8_rsp_ovf;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int cyc;

  always #5 clk = ~clk;

  csa8_wide_add_sched #(.WIDTH(32)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_id     (rsp_id)
`ifdef CSA8_SCHED_OVF_EN
    ,
    .rsp_ovf    (rsp_ovf)
`endif
  );

  csa8_wide_add_sched #(.WIDTH(8)) u_dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (d8_req0_valid),
    .req0_ready (d8_req0_ready),
    .req0_a     (d8_req0_a),
    .req0_b     (d8_req0_b),
    .req0_cin   (d8_req0_cin),
    .req1_valid (d8_req1_valid),
    .req1_ready (d8_req1_ready),
    .req1_a     (d8_req1_a),
    .req1_b     (d8_req1_b),
    .req1_cin   (d8_req1_cin),
    .rsp_valid  (d8_rsp_valid),
    .rsp_ready  (d8_rsp_ready),
    .rsp_sum    (d8_rsp_sum),
    .rsp_cout   (d8_rsp_cout),
    .rsp_id     (d8_rsp_id)
`ifdef CSA8_SCHED_OVF_EN
    ,
    .rsp_ovf    (d8_rsp_ovf)
`endif
  );

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // called right after the handshake edge; returns cycles since handshake
  task automatic wait_rsp(input string tag, output int n);
    n = 1;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    if (!rsp_valid) chk_val({tag, " timeout"}, 64'(rsp_valid), 64'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    req0_valid = 1'b1;  req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0;  req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    rsp_ready  = 1'b0;
    d8_req0_valid = 1'b0; d8_req0_a = '0; d8_req0_b = '0; d8_req0_cin = 1'b0;
    d8_req1_valid = 1'b0; d8_req1_a = '0; d8_req1_b = '0; d8_req1_cin = 1'b0;
    d8_rsp_ready  = 1'b1;

    // reset state
    tick(); tick();
    chk_val("rst rsp_valid", 64'(rsp_valid), 64'd0);
    chk_val("rst rsp_sum",   64'(rsp_sum),   64'd0);
    chk_val("rst rsp_cout",  64'(rsp_cout),  64'd0);
    chk_val("rst rsp_id",    64'(rsp_id),    64'd0);
    chk_val("rst req0_ready", 64'(req0_ready), 64'd0);
    req0_valid = 1'b0;
    rst_n = 1'b1;

    // full wrap
    req0_a = 32'hFFFF_FFFF; req0_b = 32'h0000_0001; req0_cin = 1'b0; req0_valid = 1'b1;
    #1 chk_val("wrap req0_ready", 64'(req0_ready), 64'd1);
    tick();
    req0_valid = 1'b0;
    wait_rsp("wrap", cyc);
    chk_val("wrap latency", 64'(cyc), 64'd5);
    chk_val("wrap sum",  64'(rsp_sum),  64'h0);
    chk_val("wrap cout", 64'(rsp_cout), 64'd1);
    chk_val("wrap id",   64'(rsp_id),   64'd0);
`ifdef CSA8_SCHED_OVF_EN
    chk_val("wrap ovf",  64'(rsp_ovf),  64'd0);
`endif
    rsp_ready = 1'b1;
    tick();
    chk_val("wrap valid drop", 64'(rsp_valid), 64'd0);
    chk_val("wrap cout held",  64'(rsp_cout),  64'd1);

    // both valid right after reset: req0 first, then req1
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    req0_a = 32'h1234_5678; req0_b = 32'h1111_1111; req0_cin = 1'b0; req0_valid = 1'b1;
    req1_a = 32'h0000_FFFF; req1_b = 32'h0000_0001; req1_cin = 1'b1; req1_valid = 1'b1;
    #1;
    chk_val("both req0_ready", 64'(req0_ready), 64'd1);
    chk_val("both req1_ready", 64'(req1_ready), 64'd0);
    tick();
    req0_valid = 1'b0;
    chk_val("run req1_ready", 64'(req1_ready), 64'd0);
    wait_rsp("both0", cyc);
    chk_val("both0 sum",  64'(rsp_sum),  64'h2345_6789);
    chk_val("both0 cout", 64'(rsp_cout), 64'd0);
    chk_val("both0 id",   64'(rsp_id),   64'd0);
    chk_val("done req1_ready", 64'(req1_ready), 64'd0);
    tick();
    chk_val("idle req1_ready", 64'(req1_ready), 64'd1);
    tick();
    req1_valid = 1'b0;
    wait_rsp("both1", cyc);
    chk_val("both1 sum",  64'(rsp_sum),  64'h0001_0001);
    chk_val("both1 cout", 64'(rsp_cout), 64'd0);
    chk_val("both1 id",   64'(rsp_id),   64'd1);
    tick();

    // round-robin alternation
    req0_a = 32'h7FFF_FFFF; req0_b = 32'h0000_0001; req0_cin = 1'b0; req0_valid = 1'b1;
    req1_a = 32'h0000_0005; req1_b = 32'hFFFF_FFFF; req1_cin = 1'b0; req1_valid = 1'b1;
    #1;
    chk_val("rr0 req0_ready", 64'(req0_ready), 64'd1);
    chk_val("rr0 req1_ready", 64'(req1_ready), 64'd0);
    tick();
    req0_valid = 1'b0;
    wait_rsp("rr0", cyc);
    chk_val("rr0 sum",  64'(rsp_sum),  64'h8000_0000);
    chk_val("rr0 cout", 64'(rsp_cout), 64'd0);
    chk_val("rr0 id",   64'(rsp_id),   64'd0);
`ifdef CSA8_SCHED_OVF_EN
    chk_val("rr0 ovf",  64'(rsp_ovf),  64'd1);
`endif
    tick();
    req0_valid = 1'b1;
    #1;
    chk_val("rr1 req1_ready", 64'(req1_ready), 64'd1);
    chk_val("rr1 req0_ready", 64'(req0_ready), 64'd0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp("rr1", cyc);
    chk_val("rr1 sum",  64'(rsp_sum),  64'h0000_0004);
    chk_val("rr1 cout", 64'(rsp_cout), 64'd1);
    chk_val("rr1 id",   64'(rsp_id),   64'd1);
`ifdef CSA8_SCHED_OVF_EN
    chk_val("rr1 ovf",  64'(rsp_ovf),  64'd0);
`endif
    tick();

    // backpressure in DONE with req1 pending
    rsp_ready = 1'b0;
    req0_a = 32'hDEAD_BEEF; req0_b = 32'h0123_4567; req0_cin = 1'b0; req0_valid = 1'b1;
    req1_a = 32'h8000_0000; req1_b = 32'h8000_0000; req1_cin = 1'b0; req1_valid = 1'b1;
    #1 chk_val("bp req0_ready", 64'(req0_ready), 64'd1);
    tick();
    req0_valid = 1'b0;
    wait_rsp("bp", cyc);
    for (int i = 0; i < 6; i++) begin
      chk_val("bp valid",      64'(rsp_valid),  64'd1);
      chk_val("bp sum",        64'(rsp_sum),    64'hDFD1_0456);
      chk_val("bp cout",       64'(rsp_cout),   64'd0);
      chk_val("bp id",         64'(rsp_id),     64'd0);
      chk_val("bp req1_ready", 64'(req1_ready), 64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #1 chk_val("bp release req1_ready", 64'(req1_ready), 64'd0);
    tick();
    chk_val("bp accept req1_ready", 64'(req1_ready), 64'd1);
    tick();
    req1_valid = 1'b0;
    wait_rsp("neg", cyc);
    chk_val("neg sum",  64'(rsp_sum),  64'h0);
    chk_val("neg cout", 64'(rsp_cout), 64'd1);
    chk_val("neg id",   64'(rsp_id),   64'd1);
`ifdef CSA8_SCHED_OVF_EN
    chk_val("neg ovf",  64'(rsp_ovf),  64'd1);
`endif
    tick();

    // async reset in the 2nd RUN cycle
    req1_a = 32'h0000_0001; req1_b = 32'h0000_0002; req1_cin = 1'b0; req1_valid = 1'b1;
    #1 tick();
    tick();
    chk_val("pre-rst sum", 64'(rsp_sum), 64'h0000_0003);
    rst_n = 1'b0;
    #1;
    chk_val("mid rst valid", 64'(rsp_valid),  64'd0);
    chk_val("mid rst sum",   64'(rsp_sum),    64'd0);
    chk_val("mid rst cout",  64'(rsp_cout),   64'd0);
    chk_val("mid rst id",    64'(rsp_id),     64'd0);
    chk_val("mid rst req1_ready", 64'(req1_ready), 64'd0);
`ifdef CSA8_SCHED_OVF_EN
    chk_val("mid rst ovf",   64'(rsp_ovf),    64'd0);
`endif
    tick();
    rst_n = 1'b1;
    #1 chk_val("post rst req1_ready", 64'(req1_ready), 64'd1);
    tick();
    req1_valid = 1'b0;
    wait_rsp("post rst", cyc);
    chk_val("post rst sum", 64'(rsp_sum), 64'h0000_0003);
    chk_val("post rst id",  64'(rsp_id),  64'd1);
    tick();

    // WIDTH=8 instance
    d8_req0_a = 8'hAA; d8_req0_b = 8'h55; d8_req0_cin = 1'b1; d8_req0_valid = 1'b1;
    #1 chk_val("w8 req0_ready", 64'(d8_req0_ready), 64'd1);
    tick();
    d8_req0_valid = 1'b0;
    cyc = 1;
    while (!d8_rsp_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    chk_val("w8 latency", 64'(cyc),         64'd2);
    chk_val("w8 sum",     64'(d8_rsp_sum),  64'h00);
    chk_val("w8 cout",    64'(d8_rsp_cout), 64'd1);
    chk_val("w8 id",      64'(d8_rsp_id),   64'd0);
`ifdef CSA8_SCHED_OVF_EN
    chk_val("w8 ovf",     64'(d8_rsp_ovf),  64'd0);
`endif
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
